// File: rtl/seven_seg_display.sv
// Eight-digit seven-segment driver for the register-file display word.
// Binary-to-BCD conversion runs as a 32-step shift-add-3 loop with blanking, sign and overflow.
module seven_seg_display (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] value,
    input  logic        signed_mode,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        neg,
    output logic        overflow,
    output logic        busy
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BCD_W   = 40;
    localparam int unsigned BCD_NIB = 10;
    localparam int unsigned DIGITS  = 8;
    localparam int unsigned CNT_W   = 5;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(DATA_W - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    logic [1:0]              state;
    logic [1:0]              nextState;
    logic                    pending;
    logic [DATA_W:0]         lastSample;
    logic [DATA_W:0]         sampleNow;
    logic                    negNext;
    logic                    loadNeg;
    logic [DATA_W-1:0]       mag;
    logic [BCD_W-1:0]        bcd;
    logic [BCD_W-1:0]        bcdAdj;
    logic [BCD_W+DATA_W-1:0] shiftNext;
    logic [CNT_W-1:0]        bitCount;
    logic                    overflowNext;
    logic [6:0]              segNext [DIGITS];

    function automatic logic [6:0] segCode(input logic [3:0] digit);
        case (digit)
            4'd0:    segCode = 7'b1000000;
            4'd1:    segCode = 7'b1111001;
            4'd2:    segCode = 7'b0100100;
            4'd3:    segCode = 7'b0110000;
            4'd4:    segCode = 7'b0011001;
            4'd5:    segCode = 7'b0010010;
            4'd6:    segCode = 7'b0000010;
            4'd7:    segCode = 7'b1111000;
            4'd8:    segCode = 7'b0000000;
            4'd9:    segCode = 7'b0010000;
            default: segCode = SEG_BLANK;
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    // Any difference from the last converted sample (or a post-reset request) starts a conversion.
    always_comb begin
        nextState = state;
        sampleNow = {signed_mode, value};
        case (state)
            IDLE:    if (pending || (sampleNow != lastSample)) nextState = LOAD;
            LOAD:    nextState = SHIFT;
            SHIFT:   if (bitCount == LAST_SHIFT) nextState = UPDATE;
            UPDATE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Add-3 correction on every nibble before the shift.
    always_comb begin
        logic [3:0] nib;
        bcdAdj  = bcd;
        loadNeg = signed_mode & value[DATA_W-1];
        for (int i = 0; i < int'(BCD_NIB); i++) begin
            nib = bcd[4*i +: 4];
            bcdAdj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        shiftNext = {bcdAdj, mag} << 1;
    end

    // Digits above the most significant nonzero one are blanked; hex0 always shows.
    always_comb begin
        logic       seen;
        logic [3:0] digit;
        segNext      = '{default: SEG_BLANK};
        overflowNext = |bcd[BCD_W-1:4*DIGITS];
        seen         = 1'b0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            digit = bcd[4*i +: 4];
            seen  = seen | (digit != 4'd0) | (i == 0);
            if (overflowNext)  segNext[i] = SEG_DASH;
            else if (seen)     segNext[i] = segCode(digit);
            else               segNext[i] = SEG_BLANK;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending    <= 1'b1;
            lastSample <= '0;
            bitCount   <= '0;
            bcd        <= '0;
            mag        <= '0;
            negNext    <= 1'b0;
            hex0       <= SEG_ZERO;
            hex1       <= SEG_BLANK;
            hex2       <= SEG_BLANK;
            hex3       <= SEG_BLANK;
            hex4       <= SEG_BLANK;
            hex5       <= SEG_BLANK;
            hex6       <= SEG_BLANK;
            hex7       <= SEG_BLANK;
            neg        <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            busy <= (nextState != IDLE);
            case (state)
                LOAD: begin
                    lastSample <= sampleNow;
                    negNext    <= loadNeg;
                    mag        <= loadNeg ? (~value + 32'd1) : value;
                    bcd        <= '0;
                    bitCount   <= '0;
                    pending    <= 1'b0;
                end
                SHIFT: begin
                    {bcd, mag} <= shiftNext;
                    bitCount   <= bitCount + CNT_W'(1);
                end
                UPDATE: begin
                    hex0     <= segNext[0];
                    hex1     <= segNext[1];
                    hex2     <= segNext[2];
                    hex3     <= segNext[3];
                    hex4     <= segNext[4];
                    hex5     <= segNext[5];
                    hex6     <= segNext[6];
                    hex7     <= segNext[7];
                    neg      <= negNext;
                    overflow <= overflowNext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_display.sv
// Scoreboard bench for seven_seg_display: expected displays are queued at stimulus time
// and compared at the fixed conversion latency.
module tb_seven_seg_display;

    logic        clock;
    logic        reset_n;
    logic [31:0] value;
    logic        signed_mode;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        neg;
    logic        overflow;
    logic        busy;

    int          vectors;
    int          miscompares;
    logic [58:0] sb [$];
    logic [31:0] lastV;
    logic        lastS;

    localparam logic [58:0] RESET_OBS = {{7{7'b1111111}}, 7'b1000000, 3'b000};

    seven_seg_display dut (
        .clock(clock), .reset_n(reset_n), .value(value), .signed_mode(signed_mode),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .neg(neg), .overflow(overflow), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [6:0] refSeg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Reference display via decimal division: {hex7..hex0, neg, overflow, busy=0}.
    function automatic logic [58:0] model(input logic [31:0] v, input logic s);
        logic [63:0] m;
        logic        n;
        logic        o;
        int          d [8];
        int          msd;
        logic [58:0] r;
        n   = s & v[31];
        m   = n ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        o   = m > 64'd99999999;
        msd = 0;
        for (int i = 0; i < 8; i++) begin
            d[i] = int'(m % 64'd10);
            m    = m / 64'd10;
            if (d[i] != 0) msd = i;
        end
        r = '0;
        for (int i = 0; i < 8; i++)
            r[3 + 7*i +: 7] = o ? 7'b0111111 : ((i <= msd) ? refSeg(d[i]) : 7'b1111111);
        r[2] = n;
        r[1] = o;
        r[0] = 1'b0;
        return r;
    endfunction

    function automatic logic [58:0] observe();
        return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0, neg, overflow, busy};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] v, input logic s);
        value       = v;
        signed_mode = s;
        lastV       = v;
        lastS       = s;
        sb.push_back(model(v, s));
    endtask

    task automatic test_reset();
        logic [58:0] obs;
        logic [58:0] exp;
        int          busyCount;
        reset_n     = 1'b0;
        value       = 32'd0;
        signed_mode = 1'b0;
        lastV       = 32'd0;
        lastS       = 1'b0;
        tick(3);
        obs = observe();
        vectors++;
        if (obs !== RESET_OBS) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, RESET_OBS);
        end
        reset_n = 1'b1;
        sb.push_back(model(32'd0, 1'b0));
        busyCount = 0;
        for (int k = 1; k <= 34; k++) begin
            tick(1);
            if (busy === 1'b1) busyCount++;
        end
        vectors++;
        if (busyCount !== 34) begin
            miscompares++;
            $display("FAIL reset_busy_cycles: got %0d expected 34", busyCount);
        end
        obs = observe();
        vectors++;
        if (obs !== {RESET_OBS[58:1], 1'b1}) begin
            miscompares++;
            $display("FAIL reset_hold: got %h expected %h", obs, {RESET_OBS[58:1], 1'b1});
        end
        tick(1);
        obs = observe();
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL reset_first_display: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_convert(input logic [31:0] vIn, input logic s, input string name);
        logic [58:0] prev;
        logic [58:0] obs;
        logic [58:0] exp;
        logic [31:0] v;
        v = vIn;
        if ({s, v} == {lastS, lastV}) v = v ^ 32'd1;
        prev = observe();
        drive(v, s);
        tick(34);
        obs = observe();
        vectors++;
        if (obs !== {prev[58:1], 1'b1}) begin
            miscompares++;
            $display("FAIL %s_hold: got %h expected %h", name, obs, {prev[58:1], 1'b1});
        end
        tick(1);
        obs = observe();
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s_display value=%h signed=%0b: got %h expected %h", name, v, s, obs, exp);
        end
        tick(3);
        obs = observe();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s_idle_hold: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic test_midchange();
        logic [58:0] obs;
        logic [58:0] exp5;
        logic [58:0] exp77;
        drive(32'd5, 1'b0);
        tick(10);
        drive(32'd77, 1'b0);
        tick(25);
        obs  = observe();
        exp5 = sb.pop_front();
        vectors++;
        if (obs !== exp5) begin
            miscompares++;
            $display("FAIL mid_first_display: got %h expected %h", obs, exp5);
        end
        tick(1);
        obs = observe();
        vectors++;
        if (obs !== {exp5[58:1], 1'b1}) begin
            miscompares++;
            $display("FAIL mid_requeue_busy: got %h expected %h", obs, {exp5[58:1], 1'b1});
        end
        tick(33);
        obs = observe();
        vectors++;
        if (obs !== {exp5[58:1], 1'b1}) begin
            miscompares++;
            $display("FAIL mid_second_hold: got %h expected %h", obs, {exp5[58:1], 1'b1});
        end
        tick(1);
        obs   = observe();
        exp77 = sb.pop_front();
        vectors++;
        if (obs !== exp77) begin
            miscompares++;
            $display("FAIL mid_second_display: got %h expected %h", obs, exp77);
        end
    endtask

    task automatic test_reset_midshift();
        logic [58:0] obs;
        logic [58:0] exp;
        value       = 32'd4321;
        signed_mode = 1'b0;
        lastV       = 32'd4321;
        lastS       = 1'b0;
        tick(10);
        reset_n = 1'b0;
        tick(1);
        obs = observe();
        vectors++;
        if (obs !== RESET_OBS) begin
            miscompares++;
            $display("FAIL midshift_reset_state: got %h expected %h", obs, RESET_OBS);
        end
        reset_n = 1'b1;
        sb.push_back(model(32'd4321, 1'b0));
        tick(34);
        obs = observe();
        vectors++;
        if (obs !== {RESET_OBS[58:1], 1'b1}) begin
            miscompares++;
            $display("FAIL midshift_restart_hold: got %h expected %h", obs, {RESET_OBS[58:1], 1'b1});
        end
        tick(1);
        obs = observe();
        exp = sb.pop_front();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL midshift_display: got %h expected %h", obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_convert(32'd12345678, 1'b0, "digits_12345678");
        test_convert(32'd99999999, 1'b0, "max_no_overflow");
        test_convert(32'd100000000, 1'b0, "overflow_100m");
        test_convert(32'hFFFFFFFF, 1'b0, "overflow_unsigned_max");
        test_convert(32'hFFFFFFFF, 1'b1, "signed_minus_one");
        test_convert(32'h80000000, 1'b1, "signed_most_negative");
        test_convert(32'h0000002A, 1'b1, "signed_42");
        test_convert(32'hFA0A1F01, 1'b1, "signed_minus_99999999");
        test_convert(32'd0, 1'b1, "signed_zero");
        for (int r = 0; r < 4; r++)
            test_convert($urandom, 1'($urandom_range(0, 1)), "random");
        test_convert(32'd7, 1'b0, "single_digit");
        test_midchange();
        test_reset_midshift();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
